rs232_tx_arbiter: RTL and testbench

Shares one rs232_tx serializer between N byte sources using round-robin arbitration.
- Drives the serializer's level tx_req / tx_data / tx_ack handshake for each granted source.
- Returns a one-cycle ack (or a timeout error) to the source that was served.
- Sits between multiple producers (e.g. debug, status, command-response) and the single UART TX line.

---
 rtl/rs232_pkg.sv | 21 ++
 rtl/rs232_rr_pick.sv | 34 +++
 rtl/rs232_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the UART TX arbitration slice: FSM states,
// byte width, baud divider terminal count and a small index helper.
package rs232_pkg;

    localparam int BYTE_W       = 8;
    localparam int BAUD_CNT_MAX = 1302;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        ABORT    = 3'd4
    } state_t;

    // Next round-robin position after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rs232_rr_pick.sv
// Combinational round-robin picker: first set request bit found when
// scanning ptr, ptr+1, ... modulo N.
module rs232_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan all N candidates starting at ptr; the first requester wins.
    always_comb begin
        int          cand;
        logic [IW-1:0] cand_idx;
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one rs232_tx serializer between N byte
// sources. Holds tx_req for REQ_HOLD cycles per byte, waits for the
// serializer's completion pulse, and returns ack or a timeout err to the
// served source.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int N              = 4,
    parameter int REQ_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int IW             = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [BYTE_W*N-1:0]   data,
    output logic [N-1:0]          ack,
    output logic [N-1:0]          err,
    output logic                  tx_req,
    output logic [BYTE_W-1:0]     tx_data,
    input  logic                  tx_ack,
    output logic                  busy,
    output logic [IW-1:0]         grant_id,
    output logic                  timeout_flag
);

    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HCW = $clog2(REQ_HOLD + 1);

    state_t              state;
    state_t              state_nxt;
    logic [HCW-1:0]      hold_cnt;
    logic [TCW-1:0]      to_cnt;
    logic [IW-1:0]       ptr;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [BYTE_W-1:0]   data_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign data_arr[g] = data[g*BYTE_W +: BYTE_W];
    end

    rs232_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs; tx_ack wins over the
    // final timeout cycle because it is tested first.
    always_comb begin
        state_nxt = state;
        tx_req    = 1'b0;
        busy      = (state != IDLE);
        ack       = '0;
        err       = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                tx_req = 1'b1;
                if (hold_cnt == HCW'(REQ_HOLD - 1)) begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_ack) begin
                    state_nxt = DONE;
                end else if (to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ABORT;
                end
            end
            DONE: begin
                ack[grant_id] = 1'b1;
                state_nxt     = IDLE;
            end
            ABORT: begin
                err[grant_id] = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold and timeout counters: count only while staying in their state,
    // so each restarts from zero on every entry and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            hold_cnt <= (state == REQ && state_nxt == REQ) ? hold_cnt + 1'b1 : '0;
            to_cnt   <= (state == WAIT_ACK && state_nxt == WAIT_ACK) ? to_cnt + 1'b1 : '0;
        end
    end

    // Grant latch, round-robin pointer advance and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id     <= '0;
            tx_data      <= '0;
            ptr          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant_id <= pick_idx;
                tx_data  <= data_arr[pick_idx];
            end
            if (state == DONE || state == ABORT) begin
                ptr <= IW'(rr_next(int'(grant_id), N));
            end
            if (state == ABORT) begin
                timeout_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter: transaction-level reference
// model compared every cycle, directed scenarios with literal
// expectations, then randomized traffic with a randomized serializer stub.
module tb_rs232_tx_arbiter;

    localparam int N  = 4;
    localparam int H  = 2;
    localparam int TO = 50;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] data = '0;
    logic [N-1:0]   ack;
    logic [N-1:0]   err;
    logic           tx_req;
    logic [7:0]     tx_data;
    logic           tx_ack = 1'b0;
    logic           busy;
    logic [IW-1:0]  grant_id;
    logic           timeout_flag;

    always #5 clk = ~clk;

    rs232_tx_arbiter #(
        .N              (N),
        .REQ_HOLD       (H),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data         (data),
        .ack          (ack),
        .err          (err),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_ack       (tx_ack),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_flag (timeout_flag)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, described by its age
    // (cycles since the grant edge) and the age at which it finishes.
    bit       m_busy;
    int       m_gid, m_ptr, m_age, m_end;
    bit       m_abort;
    bit [7:0] m_byte;
    bit       m_flag;

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_byte = 0;
            m_flag = 0; m_age = 0; m_end = 0; m_abort = 0;
            return;
        end
        if (m_busy) begin
            if (m_end != 0 && m_age == m_end) begin
                m_busy = 0;
                m_ptr  = (m_gid + 1) % N;
                if (m_abort) m_flag = 1;
            end else begin
                if (m_end == 0 && m_age > H) begin
                    if (tx_ack) begin
                        m_end = m_age + 1; m_abort = 0;
                    end else if (m_age - H - 1 == TO - 1) begin
                        m_end = m_age + 1; m_abort = 1;
                    end
                end
                m_age++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req[c]) begin
                    m_busy = 1; m_gid = c; m_byte = data[8*c +: 8];
                    m_age = 1; m_end = 0;
                    break;
                end
            end
        end
    endtask

    // Compare process: every cycle the DUT outputs against the model.
    bit           chk_en = 0;
    logic [N-1:0] e_ack, e_err;
    logic         e_txreq;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_txreq = m_busy && m_age >= 1 && m_age <= H;
                e_ack = (m_busy && m_end != 0 && m_age == m_end && !m_abort) ? N'(1 << m_gid) : '0;
                e_err = (m_busy && m_end != 0 && m_age == m_end &&  m_abort) ? N'(1 << m_gid) : '0;
                chk("busy",         32'(busy),         32'(m_busy));
                chk("tx_req",       32'(tx_req),       32'(e_txreq));
                chk("ack",          32'(ack),          32'(e_ack));
                chk("err",          32'(err),          32'(e_err));
                chk("tx_data",      32'(tx_data),      32'(m_byte));
                chk("timeout_flag", 32'(timeout_flag), 32'(m_flag));
                if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_gid));
            end
        end
    end

    // Sources, serializer stub and logs.
    bit [7:0] srcq [N][$];
    bit [7:0] tx_log[$];
    int       gid_log[$];
    int       ack_log[$];
    int       ack_cyc_log[$];
    int       err_log[$];
    int       ncyc = 0;
    int       wait_entry = 0;
    int       err_dist = 0;
    bit       prev_txreq = 0;
    bit       wact = 0;
    int       w = 0;
    int       tgt = 0;
    int       stub_mode = 2;   // 0 random, 1 never ack, 2 fixed delay
    int       stub_j = 1;
    bit       spur_en = 0;

    function automatic int pick_target();
        int r;
        if (stub_mode == 1) return 1000;
        if (stub_mode == 2) return stub_j;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, 8));
        if (r == 7) return 48 + int'($urandom_range(0, 1));
        if (r == 8) return 50;
        return 1000;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]         = (srcq[i].size() > 0);
            data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
        end
    endtask

    task automatic clear_logs();
        tx_log.delete(); gid_log.delete(); ack_log.delete();
        ack_cyc_log.delete(); err_log.delete();
    endtask

    task automatic cyc();
        bit txa;
        @(posedge clk);
        model_step();
        @(negedge clk);
        ncyc++;
        if (tx_req && !prev_txreq) begin
            tx_log.push_back(tx_data);
            gid_log.push_back(int'(grant_id));
        end
        if (ack != 0) begin
            ack_log.push_back(int'(ack));
            ack_cyc_log.push_back(ncyc);
        end
        if (err != 0) begin
            err_log.push_back(int'(err));
            err_dist = ncyc - wait_entry;
        end
        if (!tx_req && prev_txreq) begin
            w = 0; wact = 1; tgt = pick_target(); wait_entry = ncyc;
        end else if (wact) begin
            w++;
        end
        if (!busy) wact = 0;
        txa = wact && (w == tgt);
        if (spur_en && (tx_req || !busy) && $urandom_range(0, 3) == 0) txa = 1;
        tx_ack     = txa;
        prev_txreq = tx_req;
        for (int i = 0; i < N; i++) begin
            if ((ack[i] || err[i]) && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        drive();
    endtask

    task automatic wait_idle(input int maxc);
        int  n = 0;
        bit  pend;
        pend = 1;
        while (pend && n < maxc) begin
            cyc();
            n++;
            pend = busy;
            for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pend = 1;
        end
        chk("drain_done", 32'(!pend), 32'd1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive();
        rst = 1;
        cyc();
        rst = 0;
        clear_logs();
    endtask

    initial begin
        int n;
        // Reset state
        cyc();
        chk_en = 1;
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_tx_req",   32'(tx_req),       32'd0);
        chk("rst_tx_data",  32'(tx_data),      32'd0);
        chk("rst_grant_id", 32'(grant_id),     32'd0);
        chk("rst_flag",     32'(timeout_flag), 32'd0);
        chk("rst_ack",      32'(ack),          32'd0);
        rst = 0;
        clear_logs();

        // Single source 2, byte A5, serializer acks in wait cycle 3
        stub_mode = 2; stub_j = 3;
        srcq[2].push_back(8'hA5);
        drive();
        n = ncyc;
        wait_idle(60);
        chk("t1_txbyte",    32'(tx_log.size() > 0 ? tx_log[0] : 0), 32'hA5);
        chk("t1_gid",       32'(gid_log.size() > 0 ? gid_log[0] : 9), 32'd2);
        chk("t1_ack",       32'(ack_log.size() > 0 ? ack_log[0] : 0), 32'b0100);
        chk("t1_ack_cycle", 32'(ack_cyc_log.size() > 0 ? ack_cyc_log[0] - n : 0), 32'd7);

        // All four from reset: in-order service and wrap
        do_reset();
        stub_mode = 2; stub_j = 1;
        srcq[0].push_back(8'h11); srcq[1].push_back(8'h22);
        srcq[2].push_back(8'h33); srcq[3].push_back(8'h44);
        drive();
        wait_idle(400);
        chk("t2_n", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() == 4) begin
            chk("t2_b0", 32'(tx_log[0]), 32'h11); chk("t2_b1", 32'(tx_log[1]), 32'h22);
            chk("t2_b2", 32'(tx_log[2]), 32'h33); chk("t2_b3", 32'(tx_log[3]), 32'h44);
        end
        if (ack_log.size() == 4) begin
            chk("t2_a0", 32'(ack_log[0]), 32'b0001); chk("t2_a1", 32'(ack_log[1]), 32'b0010);
            chk("t2_a2", 32'(ack_log[2]), 32'b0100); chk("t2_a3", 32'(ack_log[3]), 32'b1000);
        end

        // Back-to-back source 1 with source 3 interleaved
        clear_logs();
        srcq[1].push_back(8'h55); srcq[1].push_back(8'h66);
        srcq[3].push_back(8'h77);
        drive();
        wait_idle(400);
        chk("t3_n", 32'(tx_log.size()), 32'd3);
        if (tx_log.size() == 3) begin
            chk("t3_b0", 32'(tx_log[0]), 32'h55); chk("t3_b1", 32'(tx_log[1]), 32'h77);
            chk("t3_b2", 32'(tx_log[2]), 32'h66);
        end

        // Timeout on source 2, then source 3 served
        clear_logs();
        stub_mode = 1;
        srcq[2].push_back(8'h9C); srcq[3].push_back(8'h3D);
        drive();
        n = 0;
        while (err_log.size() == 0 && n < 200) begin cyc(); n++; end
        chk("t4_err_seen", 32'(err_log.size()), 32'd1);
        chk("t4_err",      32'(err_log.size() > 0 ? err_log[0] : 0), 32'b0100);
        chk("t4_err_dist", 32'(err_dist), 32'd50);
        stub_mode = 2; stub_j = 2;
        wait_idle(200);
        chk("t4_next_ack", 32'(ack_log.size() > 0 ? ack_log[0] : 0), 32'b1000);
        chk("t4_flag",     32'(timeout_flag), 32'd1);
        for (int i = 0; i < 5; i++) cyc();
        chk("t4_flag_sticky", 32'(timeout_flag), 32'd1);

        // Reset during WAIT_ACK with all four requesting, pointer at 2
        srcq[1].push_back(8'hB1);
        drive();
        wait_idle(100);
        clear_logs();
        stub_mode = 1;
        srcq[0].push_back(8'hC0); srcq[1].push_back(8'hC1);
        srcq[2].push_back(8'hC2); srcq[3].push_back(8'hC3);
        drive();
        n = 0;
        while (!(wact && w == 5) && n < 100) begin cyc(); n++; end
        chk("t6_in_wait", 32'(gid_log.size() > 0 ? gid_log[0] : 9), 32'd2);
        rst = 1;
        cyc();
        chk("t6_ack",   32'(ack),          32'd0);
        chk("t6_err",   32'(err),          32'd0);
        chk("t6_txreq", 32'(tx_req),       32'd0);
        chk("t6_busy",  32'(busy),         32'd0);
        chk("t6_gid",   32'(grant_id),     32'd0);
        chk("t6_txd",   32'(tx_data),      32'd0);
        chk("t6_flag",  32'(timeout_flag), 32'd0);
        rst = 0;
        clear_logs();
        stub_mode = 2; stub_j = 0;
        wait_idle(400);
        chk("t6_first_gid", 32'(gid_log.size() > 0 ? gid_log[0] : 9), 32'd0);
        chk("t6_first_b",   32'(tx_log.size() > 0 ? tx_log[0] : 0), 32'hC0);
        chk("t6_no_err",    32'(err_log.size()), 32'd0);

        // tx_ack on the final timeout cycle, spurious acks in IDLE/REQ
        clear_logs();
        stub_mode = 2; stub_j = 49; spur_en = 1;
        srcq[0].push_back(8'hE0);
        drive();
        wait_idle(200);
        chk("t5_ack_n", 32'(ack_log.size()), 32'd1);
        chk("t5_ack",   32'(ack_log.size() > 0 ? ack_log[0] : 0), 32'b0001);
        chk("t5_err_n", 32'(err_log.size()), 32'd0);
        chk("t5_flag",  32'(timeout_flag), 32'd0);

        // Randomized traffic
        stub_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(0, 15) == 0)
                    srcq[i].push_back(8'($urandom));
            end
            rst = ($urandom_range(0, 399) == 0);
            drive();
            cyc();
        end
        rst = 0;
        stub_mode = 2; stub_j = 2; spur_en = 0;
        wait_idle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
